ifetch_ctrl: RTL
================

Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the simple CPU. It owns the program counter and drives the instruction ROM's addr/ready request, capturing dout whenever en_out is high. Fetched words go into a small FIFO that feeds decode. The block handles stalls, jump redirects with flush, halt, and PC wrap-around.

Parameters:
DWIDTH, 16, instruction width; matches the ROM dout width.
AWIDTH, 16, PC and ROM address width.
DEPTH, 16, program length in words; the PC wraps from DEPTH-1 to 0.
BUF_DEPTH, 2, instruction FIFO entries; must be 2 or 4.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
rom_addr  output  AWIDTH  ROM address; always equals pc.
rom_ready  output  1  ROM request strobe.
rom_dout  input  DWIDTH  ROM read data; valid in the same cycle as rom_en.
rom_en  input  1  ROM valid (en_out).
ir  output  DWIDTH  head-of-FIFO instruction.
ir_pc  output  AWIDTH  address of ir.
ir_valid  output  1  FIFO non-empty.
ir_take  input  1  decode pops the head this cycle; ignored when ir_valid=0.
jump_en  input  1  redirect request.
jump_addr  input  AWIDTH  redirect target.
halt  input  1  level-sensitive; suspends fetching.
jump_err  output  1  sticky; set when jump_addr >= DEPTH.
fetch_cnt  output  16  performance counter (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=0, FIFO empty, ir=0, ir_pc=0, ir_valid=0.
  - rom_ready=0, rom_addr=0, jump_err=0, fetch_cnt=0, state=IDLE.
- States:
  - IDLE: exits unconditionally to RUN on the first clk edge after reset release (halt=1 sends it to HALT instead).
  - RUN: normal fetching.
  - HALT: entered when halt=1 is sampled in RUN; returns to RUN on the edge where halt=0 is sampled.
- rom_ready (combinational) = (state==RUN) && (count<BUF_DEPTH) && !jump_en. It does not depend on ir_take.
- Accept: on a clk edge with rom_ready=1 and rom_en=1:
  - push {rom_dout, pc} into the FIFO;
  - pc <= (pc==DEPTH-1) ? 0 : pc+1.
  - If rom_en=0, pc holds and the request stays up next cycle.
- Pop: on a clk edge with ir_take=1 and ir_valid=1, the head is removed.
  - Push and pop in the same cycle: count unchanged, order preserved.
- Latency: reset release at edge 0.
  - Edge 1: IDLE->RUN.
  - Cycle 2: rom_ready=1 with addr 0; the word is accepted at edge 2.
  - Cycle 3: ir_valid=1 with mem[0].
  - Sustained throughput is 1 word/cycle while decode takes every cycle.
- FIFO full: rom_ready=0 and pc is held. Fetch resumes the cycle after a pop.
- Jump (jump_en=1 at a clk edge) has priority over everything else:
  - FIFO flushed; any same-cycle ir_take is ignored; no push occurs.
  - pc <= jump_addr if jump_addr < DEPTH; otherwise pc <= 0 and jump_err <= 1.
  - Earliest ir_valid for the target word is 2 cycles after the jump edge.
- Jump during HALT: pc updated and FIFO flushed; the block stays in HALT.
- HALT: rom_ready=0. The FIFO still drains via ir_take. pc is held.
- Reset mid-operation: all state clears immediately, regardless of any pending ROM handshake.
- fetch_cnt increments on every accept, including words later flushed, and saturates at 16'hFFFF.

Optional Feature:
IFETCH_PERF_EN
- Defined: fetch_cnt behaves as described above.
- Undefined: no counter logic is built and fetch_cnt is tied to 16'h0000. The port list is unchanged.

Test Plan:
- Reset, then ir_take=1 every cycle with the CPU test program loaded → ir/ir_pc sequence 0x0000/0, 0x0008/1, 0xF002/2, first ir_valid in cycle 3, one word per cycle thereafter.
- ir_take=0 held → after 2 accepts rom_ready=0 and pc=2. Single pop → exactly one more accept; pc=3, FIFO full again.
- Decode sees ir=0xA007 (JUMP #7) and drives jump_en=1, jump_addr=7 while the FIFO holds mem[9] → flush; next ir=0xD40B with ir_pc=7; fetch_cnt still counts the flushed word.
- DEPTH=16, free-running fetch → ir_pc 14, 15, 0, 1; no gap at the wrap.
- jump_addr=20 → pc=0, jump_err=1 and it stays 1 until rst.
- halt=1 with 2 words buffered → rom_ready=0, both words drain, ir_valid drops; halt=0 → fetch resumes at the held pc. Assert rst=0 mid-fetch → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/ifetch_ctrl_if.sv
// Fetch-unit bus: ROM request/response plus decode-side instruction stream and control.
interface ifetch_ctrl_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
);
  logic [AWIDTH-1:0] rom_addr;
  logic              rom_ready;
  logic [DWIDTH-1:0] rom_dout;
  logic              rom_en;
  logic [DWIDTH-1:0] ir;
  logic [AWIDTH-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_take;
  logic              jump_en;
  logic [AWIDTH-1:0] jump_addr;
  logic              halt;
  logic              jump_err;
  logic [15:0]       fetch_cnt;

  modport master (
    output rom_addr, rom_ready, ir, ir_pc, ir_valid, jump_err, fetch_cnt,
    input  rom_dout, rom_en, ir_take, jump_en, jump_addr, halt
  );

  modport slave (
    input  rom_addr, rom_ready, ir, ir_pc, ir_valid, jump_err, fetch_cnt,
    output rom_dout, rom_en, ir_take, jump_en, jump_addr, halt
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, requests ROM words, buffers them for decode.
// Optional fetch counter built only when IFETCH_PERF_EN is defined.
module ifetch_ctrl #(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 16,
  parameter int DEPTH     = 16,
  parameter int BUF_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  ifetch_ctrl_if.master bus
);
  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_nx;

  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] buf_d  [BUF_DEPTH];
  logic [AWIDTH-1:0] buf_pc [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              ir_valid;
  logic              rom_ready;
  logic              accept, pop;

  assign ir_valid = (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rom_ready = 1'b0;
    unique case (state)
      IDLE: state_nx = bus.halt ? HALT : RUN;
      RUN: begin
        rom_ready = (count < CW'(BUF_DEPTH)) && !bus.jump_en;
        state_nx  = bus.halt ? HALT : RUN;
      end
      HALT: state_nx = bus.halt ? HALT : RUN;
      default: state_nx = IDLE;
    endcase
    accept = rom_ready && bus.rom_en;
    // A jump flushes the buffer, so a same-cycle pop is meaningless
    pop    = bus.ir_take && ir_valid && !bus.jump_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.jump_err <= 1'b0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_d[i]  <= '0;
        buf_pc[i] <= '0;
      end
    end else if (bus.jump_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (bus.jump_addr < AWIDTH'(DEPTH)) begin
        pc <= bus.jump_addr;
      end else begin
        pc           <= '0;
        bus.jump_err <= 1'b1;
      end
    end else begin
      if (accept) begin
        buf_d[wr_ptr]  <= bus.rom_dout;
        buf_pc[wr_ptr] <= pc;
        wr_ptr         <= wr_ptr + PW'(1);
        pc             <= (pc == AWIDTH'(DEPTH - 1)) ? '0 : pc + AWIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (accept && !pop)      count <= count + CW'(1);
      else if (!accept && pop) count <= count - CW'(1);
    end
  end

  assign bus.rom_addr  = pc;
  assign bus.rom_ready = rom_ready;
  assign bus.ir_valid  = ir_valid;
  assign bus.ir        = ir_valid ? buf_d[rd_ptr]  : '0;
  assign bus.ir_pc     = ir_valid ? buf_pc[rd_ptr] : '0;

`ifdef IFETCH_PERF_EN
  logic [15:0] fetch_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                fetch_cnt <= '0;
    else if (accept && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
  end

  assign bus.fetch_cnt = fetch_cnt;
`else
  assign bus.fetch_cnt = '0;
`endif
endmodule
